display_scan_ctrl: RTL and testbench

- Producer side of the vending-machine 7-segment path. Generates the 4-bit `codigo` symbol stream that the segment decoder consumes.
- Converts a credit value or selects a fixed message, holds it in a 4-digit buffer, and time-multiplexes the digits.
- Drives active-low digit anodes, aligned to the decoder's one-cycle registered segment output.

---
 rtl/display_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Producer side of the 7-segment path: converts a credit value or selects a
// fixed message into a 4-digit symbol buffer and time-multiplexes it.
module display_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carregar,
  input  logic [1:0] msg_sel,
  input  logic [6:0] valor,
  output logic       ocupado,
  output logic [3:0] codigo,
  output logic [3:0] digito
);

  // state  | meaning
  // S_IDLE | buffer stable, loads accepted
  // S_CONV | load latched; subtracting tens or about to commit

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [3:0] SYM_S     = 4'd5;
  localparam logic [3:0] SYM_E     = 4'd8;
  localparam logic [3:0] SYM_R     = 4'd9;
  localparam logic [3:0] SYM_P     = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd14;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t         state, state_nxt;
  logic [1:0]     msg_q;
  logic [6:0]     tmp;
  logic [3:0]     dezenas;
  logic [3:0]     b [4];
  logic [3:0]     cv [4];
  logic [DW-1:0]  div_cnt;
  logic [1:0]     idx, idx_d;
  logic           load, sub, commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sub       = 1'b0;
    commit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (carregar) begin
          load      = 1'b1;
          state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (msg_q == 2'b00 && tmp <= 7'd99 && tmp >= 7'd10) begin
          sub = 1'b1;
        end else begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer image written at commit; out-of-range numerics fall back to "Err"
  always_comb begin
    cv[0] = SYM_BLANK;
    cv[1] = SYM_BLANK;
    cv[2] = SYM_BLANK;
    cv[3] = SYM_BLANK;
    unique case (msg_q)
      2'b00: begin
        if (tmp > 7'd99) begin
          cv[0] = SYM_E;
          cv[1] = SYM_R;
          cv[2] = SYM_R;
        end else begin
          cv[2] = (dezenas == 4'd0) ? SYM_BLANK : dezenas;
          cv[3] = tmp[3:0];
        end
      end
      2'b01: begin
        cv[0] = SYM_E;
        cv[1] = SYM_R;
        cv[2] = SYM_R;
      end
      2'b10: begin
        cv[0] = SYM_S;
        cv[1] = SYM_P;
      end
      default: ;
    endcase
  end

  assign ocupado = (state == S_CONV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q   <= 2'b00;
      tmp     <= 7'd0;
      dezenas <= 4'd0;
      for (int i = 0; i < 4; i++) b[i] <= SYM_BLANK;
    end else begin
      if (load) begin
        msg_q   <= msg_sel;
        tmp     <= valor;
        dezenas <= 4'd0;
      end else if (sub) begin
        tmp     <= tmp - 7'd10;
        dezenas <= dezenas + 4'd1;
      end
      if (commit) begin
        for (int i = 0; i < 4; i++) b[i] <= cv[i];
      end
    end
  end

  // Scan runs freely; loads never disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      idx_d   <= 2'd0;
      codigo  <= SYM_BLANK;
      digito  <= 4'b1111;
    end else begin
      if (div_cnt == DW'(DIV - 1)) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      idx_d  <= idx;
      codigo <= b[idx];
      // anode lags codigo by one cycle to line up with the decoder's seg register
      digito <= ~(4'b1000 >> idx_d);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=4: scan timing, load vectors
// and the busy/reset corner cases.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       carregar;
  logic [1:0] msg_sel;
  logic [6:0] valor;
  logic       ocupado;
  logic [3:0] codigo;
  logic [3:0] digito;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(.DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .carregar (carregar),
    .msg_sel  (msg_sel),
    .valor    (valor),
    .ocupado  (ocupado),
    .codigo   (codigo),
    .digito   (digito)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  msg;
    logic [6:0]  val;
    int          busy;
    logic [15:0] buf_exp;
  } vec_t;

  vec_t       vecs [10];
  logic [3:0] scan_exp [20];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Watches 20 cycles of scan, pairing each anode with the codigo one cycle earlier
  task automatic check_buf(input string nm, input logic [15:0] e);
    logic [3:0] got [4];
    logic       seen [4];
    logic [3:0] pc;
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 1'b0;
      got[i]  = 4'd0;
    end
    pc = codigo;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (digito)
        4'b0111: begin got[0] = pc; seen[0] = 1'b1; end
        4'b1011: begin got[1] = pc; seen[1] = 1'b1; end
        4'b1101: begin got[2] = pc; seen[2] = 1'b1; end
        4'b1110: begin got[3] = pc; seen[3] = 1'b1; end
        default: ;
      endcase
      pc = codigo;
    end
    for (int i = 0; i < 4; i++) begin
      ev = e[15 - 4*i -: 4];
      chk($sformatf("%s b[%0d]", nm, i), seen[i] ? int'(got[i]) : -1, int'(ev));
    end
  endtask

  task automatic do_load(input logic [1:0] m, input logic [6:0] v, output int busy);
    @(negedge clk);
    carregar = 1'b1;
    msg_sel  = m;
    valor    = v;
    @(negedge clk);
    carregar = 1'b0;
    busy     = 0;
    while (ocupado && busy < 30) begin
      busy++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy;
    logic [3:0] held_exp [4];

    vecs[0] = '{2'b00, 7'd57,  6,  {4'd14, 4'd14, 4'd5,  4'd7}};
    vecs[1] = '{2'b00, 7'd7,   1,  {4'd14, 4'd14, 4'd14, 4'd7}};
    vecs[2] = '{2'b00, 7'd0,   1,  {4'd14, 4'd14, 4'd14, 4'd0}};
    vecs[3] = '{2'b00, 7'd99,  10, {4'd14, 4'd14, 4'd9,  4'd9}};
    vecs[4] = '{2'b00, 7'd120, 1,  {4'd8,  4'd9,  4'd9,  4'd14}};
    vecs[5] = '{2'b11, 7'd33,  1,  {4'd14, 4'd14, 4'd14, 4'd14}};
    vecs[6] = '{2'b01, 7'd42,  1,  {4'd8,  4'd9,  4'd9,  4'd14}};
    vecs[7] = '{2'b10, 7'd0,   1,  {4'd5,  4'd10, 4'd14, 4'd14}};
    vecs[8] = '{2'b00, 7'd10,  2,  {4'd14, 4'd14, 4'd1,  4'd0}};
    vecs[9] = '{2'b00, 7'd100, 1,  {4'd8,  4'd9,  4'd9,  4'd14}};

    for (int k = 0; k < 20; k++) begin
      if (k < 5)       scan_exp[k] = 4'b0111;
      else if (k < 9)  scan_exp[k] = 4'b1011;
      else if (k < 13) scan_exp[k] = 4'b1101;
      else if (k < 17) scan_exp[k] = 4'b1110;
      else             scan_exp[k] = 4'b0111;
    end

    held_exp[0] = 4'd1;
    held_exp[1] = 4'd0;
    held_exp[2] = 4'd1;
    held_exp[3] = 4'd0;

    rst      = 1'b1;
    carregar = 1'b0;
    msg_sel  = 2'b00;
    valor    = 7'd0;

    // reset release and free-running scan
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset codigo", int'(codigo), 14);
    chk("reset digito", int'(digito), 4'b1111);
    chk("reset ocupado", int'(ocupado), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("scan digito k=%0d", k + 1), int'(digito), int'(scan_exp[k]));
      chk($sformatf("scan codigo k=%0d", k + 1), int'(codigo), 14);
    end

    // load vectors
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].msg, vecs[i].val, busy);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check_buf($sformatf("vec%0d", i), vecs[i].buf_exp);
    end

    // carregar held across the commit edge: ignored there, accepted one cycle later
    @(negedge clk);
    carregar = 1'b1;
    msg_sel  = 2'b10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("held ocupado c=%0d", c), int'(ocupado), int'(held_exp[c]));
      if (c == 2) carregar = 1'b0;
    end
    check_buf("held", {4'd5, 4'd10, 4'd14, 4'd14});

    // pulse during a conversion is dropped, not queued
    @(negedge clk);
    carregar = 1'b1;
    msg_sel  = 2'b00;
    valor    = 7'd90;
    @(negedge clk);
    carregar = 1'b0;
    busy     = 0;
    while (ocupado && busy < 30) begin
      busy++;
      if (busy == 3) begin
        carregar = 1'b1;
        msg_sel  = 2'b01;
      end else begin
        carregar = 1'b0;
      end
      @(negedge clk);
    end
    carregar = 1'b0;
    chk("ignore busy", busy, 10);
    busy = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ocupado) busy++;
    end
    chk("ignore not queued", busy, 0);
    check_buf("ignore", {4'd14, 4'd14, 4'd9, 4'd0});

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    carregar = 1'b1;
    msg_sel  = 2'b00;
    valor    = 7'd80;
    @(negedge clk);
    carregar = 1'b0;
    @(negedge clk);
    chk("pre-reset ocupado", int'(ocupado), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst ocupado", int'(ocupado), 0);
    chk("async rst codigo", int'(codigo), 14);
    chk("async rst digito", int'(digito), 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    busy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ocupado) busy++;
    end
    chk("post-reset ocupado", busy, 0);
    check_buf("post-reset", {4'd14, 4'd14, 4'd14, 4'd14});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
